// File: rtl/line_fill_buffer.sv
// Cache-line refill engine: fetches one line in critical-word-first wrap order,
// forwards the critical word early and presents the assembled line with tag/index.
//
// state | meaning
// IDLE  | waiting for fill_req; address fields latched on acceptance
// FILL  | issuing beat addresses and collecting returned words
// DONE  | line complete; line_valid asserted for this single cycle
module line_fill_buffer #(
  parameter int CACHE_LINE = 128,
  parameter int CACHE_SIZE = 8192,
  localparam int BEATS = CACHE_LINE / 32,
  localparam int OFF_W = $clog2(BEATS),
  localparam int IDX_W = $clog2(CACHE_SIZE * 8 / CACHE_LINE),
  localparam int TAG_W = 30 - IDX_W - OFF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_req,
  input  logic [31:0]           fill_addr,
  output logic                  fill_busy,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  crit_valid,
  output logic [31:0]           crit_data,
  output logic                  line_valid,
  output logic [CACHE_LINE-1:0] line_data,
  output logic [TAG_W-1:0]      line_tag,
  output logic [IDX_W-1:0]      line_index
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OFF_W:0] CNT_ONE   = (OFF_W+1)'(1);
  localparam logic [OFF_W:0] CNT_BEATS = (OFF_W+1)'(BEATS);
  localparam logic [OFF_W:0] CNT_LAST  = (OFF_W+1)'(BEATS - 1);

  logic [1:0]            state;
  logic [TAG_W-1:0]      tag_q;
  logic [IDX_W-1:0]      idx_q;
  logic [OFF_W-1:0]      start_off;
  logic [OFF_W:0]        issued;
  logic [OFF_W:0]        received;
  logic [CACHE_LINE-1:0] line_q;
  logic [31:0]           crit_q;
  logic                  crit_valid_q;

  logic                  beat_accept;
  logic [OFF_W-1:0]      issue_word;
  logic [OFF_W-1:0]      wr_word;
  logic [1:0]            addr_lsb_unused;

  assign addr_lsb_unused = fill_addr[1:0];

  // A beat is only taken against an address acked in an earlier cycle, so the
  // comparison uses the counters as they stood before this cycle's ack.
  assign beat_accept = (state == S_FILL) && mem_rvalid && (received < issued);
  assign issue_word  = start_off + issued[OFF_W-1:0];
  assign wr_word     = start_off + received[OFF_W-1:0];

  assign fill_busy  = (state != S_IDLE);
  assign mem_req    = (state == S_FILL) && (issued < CNT_BEATS);
  assign mem_addr   = mem_req ? {tag_q, idx_q, issue_word, 2'b00} : 32'h0;
  assign line_valid = (state == S_DONE);
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_q;
  assign line_data  = line_q;
  assign line_tag   = tag_q;
  assign line_index = idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      start_off    <= '0;
      issued       <= '0;
      received     <= '0;
      line_q       <= '0;
      crit_q       <= '0;
      crit_valid_q <= 1'b0;
    end else begin
      crit_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fill_req) begin
            state     <= S_FILL;
            tag_q     <= fill_addr[31 -: TAG_W];
            idx_q     <= fill_addr[2+OFF_W +: IDX_W];
            start_off <= fill_addr[2 +: OFF_W];
            issued    <= '0;
            received  <= '0;
          end
        end
        S_FILL: begin
          if (mem_req && mem_ack) begin
            issued <= issued + CNT_ONE;
          end
          if (beat_accept) begin
            for (int k = 0; k < BEATS; k++) begin
              if (wr_word == OFF_W'(k)) begin
                line_q[32*k +: 32] <= mem_rdata;
              end
            end
            received <= received + CNT_ONE;
            if (received == '0) begin
              crit_q       <= mem_rdata;
              crit_valid_q <= 1'b1;
            end
            if (received == CNT_LAST) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_buffer.sv
// Scoreboard bench for line_fill_buffer: a 4-beat and an 8-beat instance share
// the memory-side stimulus; only the instance under test receives fill_req.
module tb_line_fill_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fill_req0, fill_req1, mem_ack, mem_rvalid;
  logic [31:0] fill_addr, mem_rdata;

  logic         fill_busy0, mem_req0, crit_valid0, line_valid0;
  logic [31:0]  mem_addr0, crit_data0;
  logic [127:0] line_data0;
  logic [18:0]  line_tag0;
  logic [8:0]   line_index0;

  logic         fill_busy1, mem_req1, crit_valid1, line_valid1;
  logic [31:0]  mem_addr1, crit_data1;
  logic [255:0] line_data1;
  logic [19:0]  line_tag1;
  logic [6:0]   line_index1;

  line_fill_buffer dut0 (
    .clk(clk), .rst(rst), .fill_req(fill_req0), .fill_addr(fill_addr),
    .fill_busy(fill_busy0), .mem_req(mem_req0), .mem_addr(mem_addr0),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .crit_valid(crit_valid0), .crit_data(crit_data0), .line_valid(line_valid0),
    .line_data(line_data0), .line_tag(line_tag0), .line_index(line_index0)
  );

  line_fill_buffer #(.CACHE_LINE(256), .CACHE_SIZE(4096)) dut1 (
    .clk(clk), .rst(rst), .fill_req(fill_req1), .fill_addr(fill_addr),
    .fill_busy(fill_busy1), .mem_req(mem_req1), .mem_addr(mem_addr1),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .crit_valid(crit_valid1), .crit_data(crit_data1), .line_valid(line_valid1),
    .line_data(line_data1), .line_tag(line_tag1), .line_index(line_index1)
  );

  logic         big;
  logic         o_busy, o_mem_req, o_crit_valid, o_line_valid;
  logic [31:0]  o_mem_addr, o_crit_data, o_tag, o_index;
  logic [255:0] o_line_data;

  assign o_busy       = big ? fill_busy1  : fill_busy0;
  assign o_mem_req    = big ? mem_req1    : mem_req0;
  assign o_mem_addr   = big ? mem_addr1   : mem_addr0;
  assign o_crit_valid = big ? crit_valid1 : crit_valid0;
  assign o_crit_data  = big ? crit_data1  : crit_data0;
  assign o_line_valid = big ? line_valid1 : line_valid0;
  assign o_line_data  = big ? line_data1  : {128'b0, line_data0};
  assign o_tag        = big ? {12'b0, line_tag1}   : {13'b0, line_tag0};
  assign o_index      = big ? {25'b0, line_index1} : {23'b0, line_index0};

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    int          ready;
  } beat_t;

  beat_t       pend_q[$];
  logic [31:0] addr_q[$];

  // Runs one fill on the selected instance. Memory returns addr - 0xA00.
  task automatic do_fill(input logic [31:0] addr, input int stall_beat, input int stall_len,
                         input bit gaps, input bit strict, input bit ign);
    int nb, off, cyc, acked, stall_cnt, crit_cnt, line_cnt, line_cyc;
    logic [31:0]  base, exp_crit, exp_tag, exp_idx;
    logic [255:0] exp_line;
    beat_t b;
    bit done;
    nb   = big ? 8 : 4;
    base = addr & ~32'(nb * 4 - 1);
    off  = int'(addr[4:2]) % nb;
    addr_q.delete();
    pend_q.delete();
    exp_line = '0;
    for (int k = 0; k < nb; k++) begin
      addr_q.push_back(base + 32'(4 * ((off + k) % nb)));
      exp_line[32*k +: 32] = base + 32'(4 * k) - 32'hA00;
    end
    exp_crit = (addr & ~32'h3) - 32'hA00;
    exp_tag  = big ? 32'(addr[31:12]) : 32'(addr[31:13]);
    exp_idx  = big ? 32'(addr[11:5])  : 32'(addr[12:4]);

    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_fill addr=%h: fill_busy got %b expected 0", addr, o_busy);
    end
    fill_addr = addr;
    if (big) fill_req1 = 1'b1; else fill_req0 = 1'b1;
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    cyc = 0; acked = 0; stall_cnt = 0; crit_cnt = 0; line_cnt = 0; line_cyc = -1; done = 1'b0;

    while (!done) begin
      @(negedge clk);
      cyc++;
      fill_req0 = 1'b0; fill_req1 = 1'b0; fill_addr = addr;
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom();
      if (ign && cyc == 3) begin
        fill_addr = 32'h0000_1F00;
        if (big) fill_req1 = 1'b1; else fill_req0 = 1'b1;
      end
      if (o_crit_valid) begin
        crit_cnt++;
        checks++;
        if (o_crit_data !== exp_crit) begin
          errors++;
          $display("FAIL crit_data addr=%h: got %h expected %h", addr, o_crit_data, exp_crit);
        end
        if (strict) begin
          checks++;
          if (cyc != 3) begin
            errors++;
            $display("FAIL crit_cycle addr=%h: got %0d expected 3", addr, cyc);
          end
        end
      end
      if (o_line_valid) begin
        line_cnt++;
        line_cyc = cyc;
        checks++;
        if (o_line_data !== exp_line) begin
          errors++;
          $display("FAIL line_data addr=%h: got %h expected %h", addr, o_line_data, exp_line);
        end
        checks++;
        if (o_tag !== exp_tag || o_index !== exp_idx) begin
          errors++;
          $display("FAIL tag_index addr=%h: got %h/%h expected %h/%h",
                   addr, o_tag, o_index, exp_tag, exp_idx);
        end
        if (strict) begin
          checks++;
          if (cyc != nb + 2) begin
            errors++;
            $display("FAIL line_cycle addr=%h: got %0d expected %0d", addr, cyc, nb + 2);
          end
        end
      end
      if (line_cyc >= 0 && cyc == line_cyc + 1) begin
        checks++;
        if (o_busy !== 1'b0 || crit_cnt != 1 || line_cnt != 1) begin
          errors++;
          $display("FAIL fill_end addr=%h: busy=%b crit_pulses=%0d line_pulses=%0d expected 0/1/1",
                   addr, o_busy, crit_cnt, line_cnt);
        end
        done = 1'b1;
      end
      if (o_mem_req) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL mem_req_extra addr=%h: got mem_req=1 expected 0", addr);
        end else begin
          if (o_mem_addr !== addr_q[0]) begin
            errors++;
            $display("FAIL mem_addr beat %0d: got %h expected %h", acked, o_mem_addr, addr_q[0]);
          end
          if (acked == stall_beat && stall_cnt < stall_len) begin
            stall_cnt++;
          end else begin
            mem_ack = 1'b1;
            b.data  = addr_q[0] - 32'hA00;
            b.ready = cyc + 1;
            pend_q.push_back(b);
            void'(addr_q.pop_front());
            acked++;
          end
        end
      end
      if (pend_q.size() > 0 && pend_q[0].ready <= cyc && (!gaps || $urandom_range(0, 2) != 0)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_q[0].data;
        void'(pend_q.pop_front());
      end else if (ign && cyc == 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end
      if (!done && cyc > 80) begin
        checks++;
        errors++;
        $display("FAIL fill_timeout addr=%h: got no completion after %0d cycles expected line_valid", addr, cyc);
        done = 1'b1;
      end
    end
    mem_ack = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      big = s[0];
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_mem_req !== 1'b0 || o_crit_valid !== 1'b0 || o_line_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d: busy/req/crit/line got %b%b%b%b expected 0000",
                 s, o_busy, o_mem_req, o_crit_valid, o_line_valid);
      end
      checks++;
      if (o_mem_addr !== 32'h0 || o_crit_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_data dut%0d: mem_addr=%h crit_data=%h expected 0", s, o_mem_addr, o_crit_data);
      end
      checks++;
      if (o_line_data !== '0 || o_tag !== 32'h0 || o_index !== 32'h0) begin
        errors++;
        $display("FAIL reset_line dut%0d: line=%h tag=%h index=%h expected 0", s, o_line_data, o_tag, o_index);
      end
    end
    big = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_aligned();
    big = 1'b0;
    do_fill(32'h0000_0A00, -1, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    big = 1'b0;
    do_fill(32'h0000_0A08, -1, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_stalls();
    big = 1'b0;
    do_fill(32'h0000_0A04, 2, 3, 1'b1, 1'b0, 1'b0);
    do_fill(32'h0000_0A0C, 1, 2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ignored();
    logic [255:0] prev_line;
    big = 1'b0;
    @(negedge clk);
    prev_line  = o_line_data;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (o_crit_valid !== 1'b0 || o_busy !== 1'b0 || o_line_data !== prev_line) begin
      errors++;
      $display("FAIL idle_rvalid: crit_valid=%b busy=%b line=%h expected 0/0/%h",
               o_crit_valid, o_busy, o_line_data, prev_line);
    end
    do_fill(32'h0000_0A0C, -1, 0, 1'b0, 1'b1, 1'b1);
    do_fill(32'h0000_0A00, -1, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    big = 1'b0;
    @(negedge clk);
    fill_addr = 32'h0000_0A08;
    fill_req0 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      fill_req0  = 1'b0;
      mem_ack    = 1'b1;
      mem_rvalid = (c >= 2);
      mem_rdata  = 32'h100 + 32'(c);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill_busy: got %b expected 1", o_busy);
    end
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({o_busy, o_mem_req, o_mem_addr, o_crit_valid, o_crit_data, o_line_valid,
         o_line_data, o_tag, o_index} !== '0) begin
      errors++;
      $display("FAIL reset_mid_fill: busy=%b req=%b addr=%h crit=%h line=%h idx=%h expected all 0",
               o_busy, o_mem_req, o_mem_addr, o_crit_data, o_line_data, o_index);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++;
      if (o_line_valid !== 1'b0 || o_crit_valid !== 1'b0 || o_busy !== 1'b0 ||
          o_line_data !== '0 || o_crit_data !== 32'h0) begin
        errors++;
        $display("FAIL late_rvalid cycle %0d: line_valid=%b crit_valid=%b busy=%b line=%h crit=%h expected all 0",
                 c, o_line_valid, o_crit_valid, o_busy, o_line_data, o_crit_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    big = 1'b0;
    do_fill(32'h0000_0A04, -1, 0, 1'b0, 1'b1, 1'b0);
    do_fill(32'h0000_0A08, -1, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sweep();
    big = 1'b1;
    do_fill(32'h0000_0A1C, -1, 0, 1'b0, 1'b1, 1'b0);
    do_fill(32'h0000_0A10, 3, 2, 1'b1, 1'b0, 1'b0);
    big = 1'b0;
  endtask

  initial begin
    rst = 1'b1; big = 1'b0;
    fill_req0 = 1'b0; fill_req1 = 1'b0; fill_addr = 32'h0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_aligned();
    test_wrap();
    test_stalls();
    test_ignored();
    test_reset_mid_fill();
    test_back_to_back();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_fill_buffer.md
# line_fill_buffer

Parametrised cache-line refill engine for the AHB I-cache miss path. On a miss it takes the faulting address and splits it into tag, index and word offset. It issues one 32-bit word read per beat in critical-word-first wrap order and assembles the returned words into a full line. The critical word is forwarded as soon as it arrives, and the completed line is presented with its tag and index for the tag/data array write.

## Interface
Parameters:
- CACHE_LINE, 128, line width in bits; a multiple of 32, with CACHE_LINE/32 a power of two ≥ 2.
- CACHE_SIZE, 8192, cache capacity in bytes.
- Derived BEATS = CACHE_LINE/32.
- Derived OFF_W = $clog2(BEATS).
- Derived IDX_W = $clog2(CACHE_SIZE*8/CACHE_LINE).
- Derived TAG_W = 30 - IDX_W - OFF_W.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- fill_req  in  1  start refill; sampled only while idle
- fill_addr  in  32  miss address; bits [1:0] ignored
- fill_busy  out  1  refill in progress
- mem_req  out  1  address valid toward memory
- mem_addr  out  32  word-aligned beat address
- mem_ack  in  1  address accepted this cycle
- mem_rvalid  in  1  read data valid; returns in issue order
- mem_rdata  in  32  read data
- crit_valid  out  1  one-cycle pulse, critical word available
- crit_data  out  32  critical word, held until next fill
- line_valid  out  1  one-cycle pulse, line complete
- line_data  out  CACHE_LINE  assembled line; word k at bits [32k+31:32k]
- line_tag  out  TAG_W  tag of filled line
- line_index  out  IDX_W  index of filled line

## Operation
- Address split: {tag, index, offset} = fill_addr[31:2]. Latched on fill_req acceptance.
- FSM states:
  - IDLE: fill_req=1 → FILL. Latch the address fields, start_off = offset, issued = 0, received = 0.
  - FILL:
    - mem_req = (issued < BEATS).
    - mem_addr = {tag, index, (start_off+issued) mod BEATS, 2'b00}.
    - mem_req & mem_ack → issued++.
    - mem_rvalid with received < issued (counted before this cycle's ack) writes mem_rdata to word (start_off+received) mod BEATS, then received++.
    - The rvalid with received == BEATS-1 → DONE.
  - DONE: line_valid = 1 for this single cycle → IDLE.
- crit_valid pulses the cycle after the first accepted rvalid. crit_data then equals that word.
- Address pipelining: multiple addresses may be outstanding (up to BEATS). mem_ack and mem_rvalid may coincide in the same cycle.
- Ignored inputs:
  - mem_rvalid with no outstanding beat (received == issued), or in IDLE/DONE.
  - fill_req while fill_busy = 1. It is not queued.
- fill_busy = (state != IDLE).
- line_data, line_tag and line_index hold their last values until the next fill writes them. Words not yet refilled in a new fill keep stale contents. Only line_valid qualifies them.
- Widths: offset arithmetic is OFF_W bits and wraps naturally. issued and received are OFF_W+1 bits.

## Timing
- Reset values: state = IDLE; all outputs 0, including line_data, crit_data, line_tag, line_index and mem_addr. Counters are 0.
- Reset mid-fill: next cycle is IDLE. No line_valid or crit_valid is emitted and the partial line is cleared. A beat returning after reset is ignored.
- Acceptance: fill_req high in cycle 0 (IDLE) → fill_busy=1 and mem_req=1 with the critical address in cycle 1.
- mem_addr is stable while mem_req=1 and mem_ack=0. It advances the cycle after ack.
- Best case (mem_ack always 1, rvalid one cycle after ack, BEATS=4): addresses in cycles 1–4, data in cycles 2–5, crit_valid in cycle 3, line_valid in cycle 6, IDLE in cycle 7. A new fill_req can be accepted in cycle 7.
- mem_rvalid in the same cycle as the ack of its own address is not accepted; data must follow its ack by at least one cycle.

## Test plan
- Aligned fill: fill_addr=0x0000_0A00, data = addr − 0xA00, ack tied high, rvalid one cycle later. Required: mem_addr 0xA00, 0xA04, 0xA08, 0xA0C; crit_data=0x0; line_data={0xC,0x8,0x4,0x0}; line_index=0xA0, line_tag=0; line_valid in cycle 6.
- Wrap fill: fill_addr=0x0000_0A08. Required: mem_addr 0xA08, 0xA0C, 0xA00, 0xA04; crit_valid with crit_data=0x8 one cycle after the first beat; same line_data as the aligned case.
- Stalls: mem_ack low for 3 cycles on beat 2, random rvalid gaps. Required: mem_addr held during the stall; final line identical; exactly one crit_valid and one line_valid.
- Ignored stimulus: fill_req=0x0000_1F00 pulsed mid-fill, plus a spurious rvalid while idle. Required: no effect; the following fill is correct.
- Reset mid-fill: rst after 2 beats. Required: all outputs 0 next cycle; a late rvalid is ignored; no line_valid.
- Parameter sweep: CACHE_LINE=256, CACHE_SIZE=4096, fill_addr=0x0000_0A1C. Required: 8 beats starting at 0xA1C and wrapping to 0xA00; line_index=0x50; line_tag=0x0.
